key_event: RTL and testbench
============================

Name: key_event

Overview:
- Sits directly downstream of the key debouncer and consumes its debounced, registered key level.
- Turns that level into single-cycle events: press, release, short click, long press and auto-repeat.
- Also provides hold-status levels and a wrapping click counter.
- Used by the UI/menu logic, which only needs pulses and never needs to time a key itself.

Parameters:
- ACTIVE_LOW, 1: 1 means key_in=0 is pressed (pull-up button); 0 means key_in=1 is pressed.
- CNT_W, 26: width of the hold counter; must hold max(LONG_CNT, REPEAT_CNT).
- LONG_CNT, 25000000: cycles from press_pulse to long_pulse (0.5 s at 50 MHz); must be >= 2.
- REPEAT_CNT, 5000000: cycles between repeat_pulse events while long-held; 0 disables repeat.

Ports:
- sys_clk  in  1  system clock; all logic on the rising edge.
- sys_rst_n  in  1  asynchronous active-low reset.
- key_in  in  1  debounced key level, synchronous to sys_clk; no internal synchroniser.
- press_pulse  out  1  one cycle high on the press edge.
- release_pulse  out  1  one cycle high on any release edge.
- click_pulse  out  1  one cycle high on a release that happens before the long threshold.
- long_pulse  out  1  one cycle high when the hold reaches LONG_CNT.
- repeat_pulse  out  1  one cycle high every REPEAT_CNT cycles in the LONG state.
- held  out  1  high while state is HOLD or LONG.
- long_held  out  1  high while state is LONG.
- click_count  out  8  number of click_pulse events, modulo 256.

Behaviour:
- pressed = ACTIVE_LOW ? ~key_in : key_in, evaluated combinationally and sampled on each rising edge.
- Reset (asynchronous, while sys_rst_n=0):
  - state=IDLE, cnt=0, click_count=0, all pulses=0, held=0, long_held=0.
  - A key already pressed at reset release gives press_pulse at the first clock edge after release.
- All outputs are registered. An event decided at edge k is visible from edge k to edge k+1, exactly one cycle wide. Pulses default to 0 every cycle.
- State IDLE:
  - pressed: press_pulse<=1, cnt<=1, go to HOLD.
  - otherwise: stay, cnt<=0.
- State HOLD:
  - not pressed: release_pulse<=1, click_pulse<=1, click_count<=click_count+1, cnt<=0, go to IDLE.
  - else if cnt==LONG_CNT: long_pulse<=1, cnt<=1, go to LONG.
  - else: cnt<=cnt+1.
- State LONG:
  - not pressed: release_pulse<=1, no click, cnt<=0, go to IDLE.
  - else if REPEAT_CNT!=0 and cnt==REPEAT_CNT: repeat_pulse<=1, cnt<=1.
  - else if REPEAT_CNT!=0: cnt<=cnt+1.
  - else (REPEAT_CNT==0): cnt holds.
- Timing:
  - long_pulse comes exactly LONG_CNT cycles after press_pulse.
  - The first repeat_pulse comes REPEAT_CNT cycles after long_pulse, then every REPEAT_CNT cycles.
- held and long_held are registered copies of the next state, so they are aligned with press_pulse and long_pulse respectively and drop together with release_pulse.
- Simultaneous events:
  - Release at the same edge where cnt==LONG_CNT counts as a click; no long_pulse.
  - Release at the same edge where cnt==REPEAT_CNT gives release only; no repeat_pulse.
- At most one of press, release, long or repeat pulse is high in any cycle; click_pulse is high only together with release_pulse.
- click_count wraps from 255 to 0 without saturating.
- Reset mid-hold drops every output immediately, with no release or click emitted.
- A press of a single cycle (IDLE, then HOLD, then IDLE) produces press_pulse and then release_pulse+click_pulse on consecutive cycles.
- cnt never exceeds max(LONG_CNT, REPEAT_CNT); an illegal state encoding recovers to IDLE.

Test Plan (bench parameters LONG_CNT=10, REPEAT_CNT=4, ACTIVE_LOW=1):
- Reset, then hold key_in=1 for 50 cycles → every pulse 0, held=0, click_count=0.
- key_in=0 for 5 cycles, then 1 → press_pulse 1 cycle, held high 5 cycles, then release_pulse and click_pulse together for 1 cycle, click_count=1, long_pulse never asserts.
- key_in=0 for 25 cycles → long_pulse exactly 10 cycles after press_pulse, repeat_pulse 4, 8 and 12 cycles after long_pulse; on release, release_pulse=1 and click_pulse=0, click_count unchanged.
- Release on the exact cycle cnt reaches 10 (key low for exactly 10 cycles) → click_pulse=1, long_pulse=0; then repeat with REPEAT_CNT=0 and a long hold → a single long_pulse and no repeats.
- 256 short clicks → click_count returns to 0 with a click_pulse on each click; then assert sys_rst_n=0 mid-hold in LONG → all outputs 0 asynchronously, no release_pulse after reset.
- Key held low through reset release → press_pulse on the first edge after reset; with ACTIVE_LOW=0, key_in=1 is treated as pressed and produces the same sequence.

Source files
------------

// File: rtl/key_event_if.sv
// Bundle between the key debouncer, the key event generator and the UI logic.
// The master side produces the events; the slave side supplies the key level.
interface key_event_if;
    logic       key_in;
    logic       press_pulse;
    logic       release_pulse;
    logic       click_pulse;
    logic       long_pulse;
    logic       repeat_pulse;
    logic       held;
    logic       long_held;
    logic [7:0] click_count;

    modport master (
        input  key_in,
        output press_pulse,
        output release_pulse,
        output click_pulse,
        output long_pulse,
        output repeat_pulse,
        output held,
        output long_held,
        output click_count
    );

    modport slave (
        output key_in,
        input  press_pulse,
        input  release_pulse,
        input  click_pulse,
        input  long_pulse,
        input  repeat_pulse,
        input  held,
        input  long_held,
        input  click_count
    );
endinterface

// File: rtl/key_event.sv
// Converts a debounced key level into registered single-cycle press/release/click/
// long/repeat events, hold-status levels and a wrapping click counter.
module key_event #(
    parameter bit ACTIVE_LOW = 1'b1,
    parameter int CNT_W      = 26,
    parameter int LONG_CNT   = 25000000,
    parameter int REPEAT_CNT = 5000000
) (
    input  logic         sys_clk,
    input  logic         sys_rst_n,
    key_event_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        LONG = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LONG_V = CNT_W'(LONG_CNT);
    localparam logic [CNT_W-1:0] REP_V  = CNT_W'(REPEAT_CNT);
    localparam logic [CNT_W-1:0] ONE_V  = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO_V = CNT_W'(0);
    localparam bit               REP_EN = (REPEAT_CNT != 0);

    function automatic logic level_to_pressed(input logic level, input logic active_low);
        return active_low ? ~level : level;
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [7:0]       click_count_r;
    logic [7:0]       click_count_nxt_s;
    logic             pressed_s;
    logic             press_r,   press_nxt_s;
    logic             release_r, release_nxt_s;
    logic             click_r,   click_nxt_s;
    logic             long_r,    long_nxt_s;
    logic             repeat_r,  repeat_nxt_s;
    logic             held_r,    held_nxt_s;
    logic             long_held_r, long_held_nxt_s;

    assign pressed_s = level_to_pressed(bus.key_in, ACTIVE_LOW);

    // Next-state, counter and event decode; release always wins over a coincident threshold.
    always_comb begin
        state_nxt_s       = state_r;
        cnt_nxt_s         = cnt_r;
        click_count_nxt_s = click_count_r;
        press_nxt_s       = 1'b0;
        release_nxt_s     = 1'b0;
        click_nxt_s       = 1'b0;
        long_nxt_s        = 1'b0;
        repeat_nxt_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (pressed_s) begin
                    press_nxt_s = 1'b1;
                    cnt_nxt_s   = ONE_V;
                    state_nxt_s = HOLD;
                end else begin
                    cnt_nxt_s   = ZERO_V;
                end
            end
            HOLD: begin
                if (!pressed_s) begin
                    release_nxt_s     = 1'b1;
                    click_nxt_s       = 1'b1;
                    click_count_nxt_s = click_count_r + 8'd1;
                    cnt_nxt_s         = ZERO_V;
                    state_nxt_s       = IDLE;
                end else if (cnt_r >= LONG_V) begin
                    // >= keeps the counter bounded even if it were ever corrupted
                    long_nxt_s  = 1'b1;
                    cnt_nxt_s   = ONE_V;
                    state_nxt_s = LONG;
                end else begin
                    cnt_nxt_s   = cnt_r + ONE_V;
                end
            end
            LONG: begin
                if (!pressed_s) begin
                    release_nxt_s = 1'b1;
                    cnt_nxt_s     = ZERO_V;
                    state_nxt_s   = IDLE;
                end else if (REP_EN && (cnt_r >= REP_V)) begin
                    repeat_nxt_s  = 1'b1;
                    cnt_nxt_s     = ONE_V;
                end else if (REP_EN) begin
                    cnt_nxt_s     = cnt_r + ONE_V;
                end else begin
                    cnt_nxt_s     = cnt_r;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = ZERO_V;
            end
        endcase
        held_nxt_s      = (state_nxt_s == HOLD) || (state_nxt_s == LONG);
        long_held_nxt_s = (state_nxt_s == LONG);
    end

    // State, counter and registered outputs.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r       <= IDLE;
            cnt_r         <= ZERO_V;
            click_count_r <= 8'd0;
            press_r       <= 1'b0;
            release_r     <= 1'b0;
            click_r       <= 1'b0;
            long_r        <= 1'b0;
            repeat_r      <= 1'b0;
            held_r        <= 1'b0;
            long_held_r   <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            cnt_r         <= cnt_nxt_s;
            click_count_r <= click_count_nxt_s;
            press_r       <= press_nxt_s;
            release_r     <= release_nxt_s;
            click_r       <= click_nxt_s;
            long_r        <= long_nxt_s;
            repeat_r      <= repeat_nxt_s;
            held_r        <= held_nxt_s;
            long_held_r   <= long_held_nxt_s;
        end
    end

    assign bus.press_pulse   = press_r;
    assign bus.release_pulse = release_r;
    assign bus.click_pulse   = click_r;
    assign bus.long_pulse    = long_r;
    assign bus.repeat_pulse  = repeat_r;
    assign bus.held          = held_r;
    assign bus.long_held     = long_held_r;
    assign bus.click_count   = click_count_r;

endmodule

// File: tb/tb_key_event.sv
// Bench for key_event: three instances (repeat on, repeat off, active-high) share one
// key stimulus; expected event cycles are queued from the timing rules and popped per cycle.
module tb_key_event;

    localparam int LONG = 10;
    localparam int REP  = 4;
    localparam logic [4:0] E_PRESS = 5'b10000;
    localparam logic [4:0] E_REL   = 5'b01000;
    localparam logic [4:0] E_CLICK = 5'b01100;
    localparam logic [4:0] E_LONG  = 5'b00010;
    localparam logic [4:0] E_REP   = 5'b00001;
    localparam logic [4:0] E_NONE  = 5'b00000;

    typedef struct {
        int          cyc;
        logic [14:0] ev;
    } exp_t;

    typedef struct {
        string name;
        int    low;
        bit    lng;
        int    nrep;
        bit    clk;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic key   = 1'b1;
    int   cyc   = 0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   exp_cc  = 0;
    exp_t sb[$];

    key_event_if b0 ();
    key_event_if b1 ();
    key_event_if b2 ();

    assign b0.key_in = key;
    assign b1.key_in = key;
    assign b2.key_in = ~key;

    key_event #(.ACTIVE_LOW(1'b1), .CNT_W(8), .LONG_CNT(LONG), .REPEAT_CNT(REP))
        u_main  (.sys_clk(clk), .sys_rst_n(rst_n), .bus(b0));
    key_event #(.ACTIVE_LOW(1'b1), .CNT_W(8), .LONG_CNT(LONG), .REPEAT_CNT(0))
        u_norep (.sys_clk(clk), .sys_rst_n(rst_n), .bus(b1));
    key_event #(.ACTIVE_LOW(1'b0), .CNT_W(8), .LONG_CNT(LONG), .REPEAT_CNT(REP))
        u_hi    (.sys_clk(clk), .sys_rst_n(rst_n), .bus(b2));

    wire [14:0] act = {b2.press_pulse, b2.release_pulse, b2.click_pulse, b2.long_pulse, b2.repeat_pulse,
                       b1.press_pulse, b1.release_pulse, b1.click_pulse, b1.long_pulse, b1.repeat_pulse,
                       b0.press_pulse, b0.release_pulse, b0.click_pulse, b0.long_pulse, b0.repeat_pulse};
    wire [2:0]  held_v = {b2.held, b1.held, b0.held};
    wire [2:0]  lh_v   = {b2.long_held, b1.long_held, b0.long_held};

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, want);
        end
    endtask

    task automatic push(input int c, input logic [4:0] e_rep, input logic [4:0] e_norep);
        exp_t e;
        e.cyc = c;
        e.ev  = {e_rep, e_norep, e_rep};
        sb.push_back(e);
    endtask

    task automatic mon();
        exp_t e;
        if (rst_n) begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                e = sb.pop_front();
                check("missed_event", 32'(e.cyc), 32'(cyc));
            end
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                check("events", 32'(act), 32'(e.ev));
            end else if (act != 15'd0) begin
                check("spurious_event", 32'(act), 32'd0);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cc(input string name);
        check({name, "_cc0"}, 32'(b0.click_count), 32'(exp_cc));
        check({name, "_cc1"}, 32'(b1.click_count), 32'(exp_cc));
        check({name, "_cc2"}, 32'(b2.click_count), 32'(exp_cc));
    endtask

    task automatic run_vec(input vec_t v);
        int s;
        s   = cyc;
        key = 1'b0;
        push(s + 1, E_PRESS, E_PRESS);
        if (v.lng) push(s + 1 + LONG, E_LONG, E_LONG);
        for (int n = 1; n <= v.nrep; n++) push(s + 1 + LONG + REP * n, E_REP, E_NONE);
        push(s + v.low + 1, v.clk ? E_CLICK : E_REL, v.clk ? E_CLICK : E_REL);
        repeat (v.low) tick();
        check({v.name, "_held"}, 32'(held_v), 32'h7);
        check({v.name, "_long_held"}, 32'(lh_v), v.lng ? 32'h7 : 32'h0);
        key = 1'b1;
        tick();
        check({v.name, "_held_drop"}, 32'({held_v, lh_v}), 32'h0);
        if (v.clk) exp_cc = (exp_cc + 1) % 256;
        tick();
        tick();
        check_cc(v.name);
        check({v.name, "_sb_empty"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        vec_t tbl[8];
        vec_t short_click;
        int   cc_before;
        int   s;
        tbl[0] = '{"single_cycle", 1,  1'b0, 0, 1'b1};
        tbl[1] = '{"short5",       5,  1'b0, 0, 1'b1};
        tbl[2] = '{"short9",       9,  1'b0, 0, 1'b1};
        tbl[3] = '{"rel_at_long",  10, 1'b0, 0, 1'b1};
        tbl[4] = '{"long11",       11, 1'b1, 0, 1'b0};
        tbl[5] = '{"rel_at_rep",   14, 1'b1, 0, 1'b0};
        tbl[6] = '{"rep_one",      15, 1'b1, 1, 1'b0};
        tbl[7] = '{"long25",       25, 1'b1, 3, 1'b0};
        short_click = '{"click", 1, 1'b0, 0, 1'b1};

        #1 rst_n = 1'b0;
        #2;
        check("reset_pulses", 32'(act), 32'd0);
        check("reset_held", 32'({held_v, lh_v}), 32'd0);
        check_cc("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        repeat (50) tick();
        check("idle_held", 32'({held_v, lh_v}), 32'd0);
        check_cc("idle");

        for (int i = 0; i < 8; i++) run_vec(tbl[i]);

        cc_before = exp_cc;
        for (int i = 0; i < 256; i++) run_vec(short_click);
        check("cc_wrap", 32'(b0.click_count), 32'(cc_before));

        // Async reset while in LONG, key still held through reset release.
        s   = cyc;
        key = 1'b0;
        push(s + 1, E_PRESS, E_PRESS);
        push(s + 1 + LONG, E_LONG, E_LONG);
        repeat (LONG + 3) tick();
        check("pre_reset_long_held", 32'(lh_v), 32'h7);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_pulses", 32'(act), 32'd0);
        check("async_rst_held", 32'({held_v, lh_v}), 32'd0);
        exp_cc = 0;
        check_cc("async_rst");
        check("rst_sb_empty", 32'(sb.size()), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        s = cyc;
        push(s + 1, E_PRESS, E_PRESS);
        repeat (3) tick();
        check("post_rst_held", 32'(held_v), 32'h7);
        key = 1'b1;
        push(s + 4, E_CLICK, E_CLICK);
        exp_cc = 1;
        repeat (3) tick();
        check_cc("post_rst");

        repeat (3) tick();
        check("final_sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
